common_dffcam_vq: RTL

- Parametrised successor to the single-port DFF CAM: DFF-based content-addressable memory with per-entry valid bits.
- Provides one write port, one invalidate port, a global flush, and QUERY_PORTS independent query ports.
- Each query port returns a hit, a multi-hit flag and a priority-encoded match address, with optional registered output.
- Also reports free-entry allocation info (lowest free index, full, occupancy count) for use by rename/tag tables and small TLB-like structures.

---
 rtl/common_dffcam_vq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/common_dffcam_vq.sv
// Flop-based CAM with per-entry valid bits, one write port, one invalidate port,
// global flush, N independent query ports and free-entry allocation outputs.
module common_dffcam_vq #(
    parameter int CAM_DEPTH            = 8,
    parameter int CAM_WIDTH            = 16,
    parameter int QUERY_PORTS          = 2,
    parameter int QUERY_REGISTERED     = 1,
    parameter int WRITE_ADDRESS_ONEHOT = 0,
    parameter int QUERY_ADDRESS_ONEHOT = 0,
    localparam int AW    = (CAM_DEPTH > 1) ? $clog2(CAM_DEPTH) : 1,
    localparam int WA    = (WRITE_ADDRESS_ONEHOT != 0) ? CAM_DEPTH : AW,
    localparam int QA    = (QUERY_ADDRESS_ONEHOT != 0) ? CAM_DEPTH : AW,
    localparam int CNT_W = $clog2(CAM_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wen,
    input  logic [WA-1:0]                  waddr,
    input  logic [CAM_WIDTH-1:0]           wdata,
    input  logic                           ien,
    input  logic [WA-1:0]                  iaddr,
    input  logic                           flush,
    input  logic [QUERY_PORTS-1:0]         qen,
    input  logic [QUERY_PORTS*CAM_WIDTH-1:0] qdata,
    output logic [QUERY_PORTS-1:0]         qhit,
    output logic [QUERY_PORTS-1:0]         qmulti,
    output logic [QUERY_PORTS*QA-1:0]      qaddr,
    output logic                           free_valid,
    output logic [QA-1:0]                  free_addr,
    output logic                           full,
    output logic [CNT_W-1:0]               count
);

    logic [CAM_WIDTH-1:0] content_q [CAM_DEPTH];
    logic [CAM_WIDTH-1:0] content_d [CAM_DEPTH];
    logic [CAM_DEPTH-1:0] valid_q, valid_d;
    logic [CAM_DEPTH-1:0] wsel, isel;

    // Out-of-range binary addresses decode to an empty select vector.
    if (WRITE_ADDRESS_ONEHOT != 0) begin : g_wsel_oh
        assign wsel = waddr;
        assign isel = iaddr;
    end else begin : g_wsel_bin
        always_comb begin
            wsel = '0;
            isel = '0;
            for (int i = 0; i < CAM_DEPTH; i++) begin
                wsel[i] = (waddr == AW'(i));
                isel[i] = (iaddr == AW'(i));
            end
        end
    end

    always_comb begin
        content_d = content_q;
        valid_d   = valid_q;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            if (wen && wsel[i])
                content_d[i] = wdata;
            if (flush)
                valid_d[i] = 1'b0;
            else if (wen && wsel[i])
                valid_d[i] = 1'b1;
            else if (ien && isel[i])
                valid_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < CAM_DEPTH; i++)
                content_q[i] <= '0;
        end else begin
            valid_q   <= valid_d;
            content_q <= content_d;
        end
    end

    logic [CAM_DEPTH-1:0]     match [QUERY_PORTS];
    logic [AW-1:0]            qidx  [QUERY_PORTS];
    logic [QUERY_PORTS-1:0]   qhit_d, qmulti_d;
    logic [QUERY_PORTS*QA-1:0] qaddr_d;

    // Clearing the lowest set bit leaves something only when two or more matched.
    always_comb begin
        qhit_d   = '0;
        qmulti_d = '0;
        for (int p = 0; p < QUERY_PORTS; p++) begin
            match[p] = '0;
            qidx[p]  = '0;
            for (int i = 0; i < CAM_DEPTH; i++)
                match[p][i] = qen[p] && valid_q[i] &&
                              (content_q[i] == qdata[p*CAM_WIDTH +: CAM_WIDTH]);
            for (int i = CAM_DEPTH - 1; i >= 0; i--)
                if (match[p][i])
                    qidx[p] = AW'(i);
            qhit_d[p]   = |match[p];
            qmulti_d[p] = |(match[p] & (match[p] - 1'b1));
        end
    end

    for (genvar p = 0; p < QUERY_PORTS; p++) begin : g_qaddr
        if (QUERY_ADDRESS_ONEHOT != 0) begin : g_oh
            assign qaddr_d[p*QA +: QA] = match[p];
        end else begin : g_bin
            assign qaddr_d[p*QA +: QA] = qidx[p];
        end
    end

    if (QUERY_REGISTERED != 0) begin : g_qreg
        logic [QUERY_PORTS-1:0]    qhit_q, qmulti_q;
        logic [QUERY_PORTS*QA-1:0] qaddr_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                qhit_q   <= '0;
                qmulti_q <= '0;
                qaddr_q  <= '0;
            end else begin
                qhit_q   <= qhit_d;
                qmulti_q <= qmulti_d;
                qaddr_q  <= qaddr_d;
            end
        end
        assign qhit   = qhit_q;
        assign qmulti = qmulti_q;
        assign qaddr  = qaddr_q;
    end else begin : g_qcomb
        assign qhit   = qhit_d;
        assign qmulti = qmulti_d;
        assign qaddr  = qaddr_d;
    end

    logic [AW-1:0]    free_idx;
    logic [CNT_W-1:0] count_sum;

    always_comb begin
        free_idx  = '0;
        count_sum = '0;
        for (int i = CAM_DEPTH - 1; i >= 0; i--)
            if (!valid_q[i])
                free_idx = AW'(i);
        for (int i = 0; i < CAM_DEPTH; i++)
            count_sum = count_sum + CNT_W'(valid_q[i]);
    end

    // Lowest zero bit of valid; wraps to zero when every entry is valid.
    if (QUERY_ADDRESS_ONEHOT != 0) begin : g_free_oh
        assign free_addr = ~valid_q & (valid_q + 1'b1);
    end else begin : g_free_bin
        assign free_addr = free_idx;
    end

    assign full       = &valid_q;
    assign free_valid = ~full;
    assign count      = count_sum;

endmodule
